ps2_kbd_tx: RTL

PS2_KBD_TX -- requirements
Module: ps2_kbd_tx

---
 rtl/ps2_kbd_tx_pkg.sv | 11 +
 rtl/ps2_kbd_tx_if.sv | 9 +
 rtl/ps2_evt_fifo.sv | 38 +++
 rtl/ps2_kbd_tx.sv | 114 +++++++++++
 4 files changed

// File: rtl/ps2_kbd_tx_pkg.sv
// ps2_kbd_tx_pkg: shared FSM states, frame constants and frame bit helper
package ps2_kbd_tx_pkg;
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_HIGH, S_LOW, S_GAP} state_t;
  localparam logic [7:0] BREAK_CODE = 8'hF0;
  localparam int FRAME_LEN = 11;
  function automatic logic frame_bit(input logic [7:0] d, input logic [3:0] i);
    logic [FRAME_LEN-1:0] f;
    f = {1'b1, ~^d, d, 1'b0};
    return f[i];
  endfunction
endpackage

// File: rtl/ps2_kbd_tx_if.sv
// ps2_kbd_tx_if: key event handshake between event source and transmitter
interface ps2_kbd_tx_if;
  logic       in_valid;
  logic [7:0] in_code;
  logic       in_release;
  logic       in_ready;
  modport master (output in_valid, in_code, in_release, input in_ready);
  modport slave (input in_valid, in_code, in_release, output in_ready);
endinterface

// File: rtl/ps2_evt_fifo.sv
// ps2_evt_fifo: small power-of-two FIFO of queued key events
module ps2_evt_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rest,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  logic do_push, do_pop;
  assign do_push = push & ~full;
  assign do_pop = pop & ~empty;
  assign full = cnt == (AW+1)'(DEPTH);
  assign empty = cnt == '0;
  assign dout = mem[rp];
  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      wp <= do_push ? wp + AW'(1) : wp;
      rp <= do_pop ? rp + AW'(1) : rp;
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
endmodule

// File: rtl/ps2_kbd_tx.sv
// ps2_kbd_tx: queues key events and shifts them out as PS/2 device-to-host frames
module ps2_kbd_tx
  import ps2_kbd_tx_pkg::*;
#(
  parameter int HALF_PERIOD = 50,
  parameter int GAP = 200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rest,
  ps2_kbd_tx_if.slave ev,
  output logic        ps2clk,
  output logic        ps2dat,
  output logic        busy,
  output logic        byte_done
);
  localparam int CMAX = HALF_PERIOD > GAP ? HALF_PERIOD : GAP;
  localparam int CW = $clog2(CMAX);
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [3:0] bidx, bidx_n;
  logic [7:0] data, data_n, pend, pend_n;
  logic [8:0] ent, ent_n, head;
  logic pend_v, pend_v_n, done_n, pop, full, empty, up, hp_end, gap_end;
  ps2_evt_fifo #(.WIDTH(9), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rest  (rest),
    .push  (ev.in_valid & ev.in_ready),
    .pop   (pop),
    .din   ({ev.in_release, ev.in_code}),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );
  // up holds in_ready low until the first edge after reset releases
  assign ev.in_ready = up & ~full;
  assign busy = state != S_IDLE || !empty;
  assign ps2clk = state != S_LOW;
  assign ps2dat = (state == S_HIGH || state == S_LOW) ? frame_bit(data, bidx) : 1'b1;
  assign hp_end = cnt == CW'(HALF_PERIOD - 1);
  assign gap_end = cnt == CW'(GAP - 1);
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    bidx_n = bidx;
    data_n = data;
    pend_n = pend;
    pend_v_n = pend_v;
    ent_n = ent;
    done_n = 1'b0;
    pop = 1'b0;
    case (state)
      S_IDLE: if (!empty) begin
        pop = 1'b1;
        ent_n = head;
        state_n = S_LOAD;
      end
      S_LOAD: begin
        data_n = ent[8] ? BREAK_CODE : ent[7:0];
        pend_n = ent[7:0];
        pend_v_n = ent[8];
        bidx_n = '0;
        cnt_n = '0;
        state_n = S_HIGH;
      end
      S_HIGH: begin
        cnt_n = hp_end ? '0 : cnt + CW'(1);
        state_n = hp_end ? S_LOW : S_HIGH;
      end
      S_LOW: begin
        cnt_n = hp_end ? '0 : cnt + CW'(1);
        if (hp_end) begin
          done_n = bidx == 4'(FRAME_LEN - 1);
          bidx_n = done_n ? bidx : bidx + 4'd1;
          state_n = done_n ? S_GAP : S_HIGH;
        end
      end
      S_GAP: begin
        cnt_n = gap_end ? '0 : cnt + CW'(1);
        if (gap_end) begin
          // the code byte of a break event follows its F0 without revisiting the FIFO
          data_n = pend_v ? pend : data;
          pend_v_n = 1'b0;
          bidx_n = '0;
          state_n = pend_v ? S_HIGH : S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rest) begin
    if (rest) begin
      state <= S_IDLE;
      cnt <= '0;
      bidx <= '0;
      data <= '0;
      pend <= '0;
      pend_v <= 1'b0;
      ent <= '0;
      byte_done <= 1'b0;
      up <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      bidx <= bidx_n;
      data <= data_n;
      pend <= pend_n;
      pend_v <= pend_v_n;
      ent <= ent_n;
      byte_done <= done_n;
      up <= 1'b1;
    end
  end
endmodule
